bomba_multi: RTL and testbench
==============================

# bomba_multi

Parametrised water-pump controller for one elevated tank fed from a cistern by `N_BOMBAS` pumps. Only one pump runs at a time, and duty rotates among the pumps after every fill. Sensors are synchronised and debounced; the block also provides anti-cycling rest, fill-timeout protection, dry-run protection, and a latched alarm with cause code and acknowledge. It sits between the raw level-probe inputs and the pump contactor/alarm drivers.

## Interface
- `N_BOMBAS`, 2: number of pumps; legal range ≥1.
- `DEB_CYC`, 16: debounce length in cycles; ≥1.
- `MIN_OFF_CYC`, 1024: forced rest after a completed fill; ≥1.
- `FILL_TIMEOUT_CYC`, 65536: maximum cycles allowed in LLENADO; ≥2.

- `ck`  in  1  clock.
- `rst_i`  in  1  reset, asynchronous, active-low.
- `nivel_bajo_i`  in  1  tank low probe; 1 = water above the low mark.
- `nivel_alto_i`  in  1  tank high probe; 1 = water above the high mark.
- `cisterna_i`  in  1  cistern probe; 1 = water available.
- `ack_i`  in  1  alarm acknowledge, level-sensitive.
- `bomba_o`  out  N_BOMBAS  pump enables, one-hot or all-zero.
- `lider_o`  out  $clog2(N_BOMBAS) (min 1)  index of the current lead pump.
- `alarma_o`  out  1  alarm active.
- `causa_o`  out  2  00 none, 01 SENSOR, 10 SECO, 11 TIMEOUT.

## Operation
- Each raw sensor passes through a 2-flop synchroniser and then a debouncer. The filtered value (`bajo`, `alto`, `cist`) toggles only after `DEB_CYC` consecutive synced samples that differ from it. A differing sample that breaks the run clears the counter.
- Filtered values reset to 1, so the block comes up in a safe "full tank, water available" condition.
- Fault priority, evaluated each cycle: SENSOR (`alto & !bajo`) > SECO (`!cist`, checked only when a pump is running or requested) > TIMEOUT.
- States:
  - **ESPERA**: pumps off.
    - SENSOR → ALARMA.
    - `!bajo & !cist` → ALARMA(SECO).
    - `!bajo & cist` → LLENADO, fill timer cleared.
  - **LLENADO**: `bomba_o` = one-hot(`lider`). Fill timer increments.
    - SENSOR → ALARMA.
    - `!cist` → ALARMA(SECO).
    - `alto` → PAUSA, `lider` advances.
    - Timer = `FILL_TIMEOUT_CYC-1` → ALARMA(TIMEOUT), `lider` advances.
  - **PAUSA**: pumps off. Rest counter runs; at `MIN_OFF_CYC-1` → ESPERA. SENSOR → ALARMA (SECO is not checked here).
  - **ALARMA**: pumps off, `alarma_o`=1, `causa_o` latched at entry.
    - Exit to ESPERA needs `ack_i`=1 and the cause condition cleared: SENSOR needs `!(alto & !bajo)`; SECO needs `cist`; TIMEOUT needs `ack_i` only.
    - While in ALARMA, a higher-priority fault overwrites `causa_o`.
- `lider` advances as (`lider`+1) mod `N_BOMBAS`. With `N_BOMBAS`=1 it stays 0.
- Counters are sized with `$clog2` and saturate only through the state exits above; they never wrap.

## Timing
- Reset (async assert, sync-safe deassert via the flops): state ESPERA, `lider`=0, `bomba_o`=0, `alarma_o`=0, `causa_o`=00, all counters 0.
- Raw-input change held stable → filtered change on clock edge `DEB_CYC+2`.
- Filtered change → state change on the next edge.
- Outputs decode combinationally from state, `lider`, and the cause register. They are valid in the same cycle as the state.
- Total sensor-to-pump latency is `DEB_CYC+3` edges.
- Simultaneous `alto` and timeout in the same cycle → PAUSA; a completed fill wins over timeout.
- Simultaneous SENSOR and `alto` → ALARMA(SENSOR).
- `ack_i` held high while a fault persists has no effect.
- `ack_i` high at the moment of fault entry does not skip ALARMA; ALARMA is held for at least 1 cycle.
- Reset mid-LLENADO drops the pump in the same cycle, asynchronously.

## Structure
- Package `bomba_pkg` holds:
  - state enum: ESPERA, LLENADO, PAUSA, ALARMA;
  - cause constants: CAUSA_NINGUNA, CAUSA_SENSOR, CAUSA_SECO, CAUSA_TIMEOUT.
- Sub-module `bomba_antirrebote` (parameter `DEB_CYC`, reset value 1) contains the synchroniser and debouncer. It is instantiated 3×.
- Top module contains the FSM, fill timer, rest counter, lead register and cause register.

## Test plan
All scenarios use `N_BOMBAS`=3, `DEB_CYC`=4, `MIN_OFF_CYC`=8, `FILL_TIMEOUT_CYC`=64.
- **Reset and first fill:** drop `nivel_bajo_i` to 0 with cistern wet → `bomba_o`=001 exactly 7 edges later; then raise `nivel_bajo_i`/`nivel_alto_i` to 1 → pumps off, PAUSA for 8 cycles, `lider_o`=1.
- **Rotation:** three complete fills → `bomba_o` sequence 001, 010, 100, then 001 again.
- **Glitch rejection:** pulse `nivel_bajo_i` low for 3 cycles → no pump activity.
- **Dry-run:** `cisterna_i`=0 during LLENADO → pumps 0, `alarma_o`=1, `causa_o`=10. `ack_i`=1 with cistern still dry → alarm stays. Cistern wet plus `ack_i` → ESPERA.
- **Timeout:** hold `nivel_alto_i`=0 for 64 cycles of LLENADO → `causa_o`=11, `lider_o` advanced; `ack_i` → ESPERA, then the next pump fills.
- **Sensor fault:** set `nivel_alto_i`=1 with `nivel_bajo_i`=0 → `causa_o`=01 and pumps off in any state. Assert `rst_i` mid-alarm → all outputs 0 immediately.

Source files
------------

// File: rtl/bomba_pkg.sv
// bomba_pkg: shared FSM state and alarm cause encodings
// for the multi-pump tank controller.
package bomba_pkg;

    typedef enum logic [1:0] {
        ESPERA  = 2'd0,
        LLENADO = 2'd1,
        PAUSA   = 2'd2,
        ALARMA  = 2'd3
    } estado_t;

    localparam logic [1:0] CAUSA_NINGUNA = 2'b00;
    localparam logic [1:0] CAUSA_SENSOR  = 2'b01;
    localparam logic [1:0] CAUSA_SECO    = 2'b10;
    localparam logic [1:0] CAUSA_TIMEOUT = 2'b11;

    // High probe wet while low probe dry is physically impossible.
    function automatic logic falla_sensor(
        input logic alto,
        input logic bajo
    );
        return alto & ~bajo;
    endfunction

endpackage

// File: rtl/bomba_antirrebote.sv
// bomba_antirrebote: 2-flop synchroniser followed by a
// run-length debouncer; everything comes out of reset at 1.
module bomba_antirrebote
    import bomba_pkg::*;
#(
    parameter int DEB_CYC = 16
) (
    input  logic ck,
    input  logic rst_i,
    input  logic raw,
    output logic filt
);

    localparam int CW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;

    always_ff @(posedge ck or negedge rst_i) begin
        if (!rst_i) begin
            s1   <= 1'b1;
            s2   <= 1'b1;
            cnt  <= '0;
            filt <= 1'b1;
        end else begin
            s1 <= raw;
            s2 <= s1;
            if (s2 == filt) begin
                cnt <= '0;
            end else if (cnt == CW'(DEB_CYC - 1)) begin
                filt <= s2;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/bomba_multi.sv
// bomba_multi: rotating-duty pump controller with anti-cycling
// rest, fill timeout, dry-run protection and latched alarm.
module bomba_multi
    import bomba_pkg::*;
#(
    parameter int N_BOMBAS         = 2,
    parameter int DEB_CYC          = 16,
    parameter int MIN_OFF_CYC      = 1024,
    parameter int FILL_TIMEOUT_CYC = 65536,
    localparam int LW = (N_BOMBAS > 1) ? $clog2(N_BOMBAS) : 1
) (
    input  logic                ck,
    input  logic                rst_i,
    input  logic                nivel_bajo_i,
    input  logic                nivel_alto_i,
    input  logic                cisterna_i,
    input  logic                ack_i,
    output logic [N_BOMBAS-1:0] bomba_o,
    output logic [LW-1:0]       lider_o,
    output logic                alarma_o,
    output logic [1:0]          causa_o
);

    localparam int TW = (FILL_TIMEOUT_CYC > 1) ?
                        $clog2(FILL_TIMEOUT_CYC) : 1;
    localparam int RW = (MIN_OFF_CYC > 1) ?
                        $clog2(MIN_OFF_CYC) : 1;

    logic bajo;
    logic alto;
    logic cist;

    bomba_antirrebote #(.DEB_CYC(DEB_CYC)) u_bajo (
        .ck    (ck),
        .rst_i (rst_i),
        .raw   (nivel_bajo_i),
        .filt  (bajo)
    );

    bomba_antirrebote #(.DEB_CYC(DEB_CYC)) u_alto (
        .ck    (ck),
        .rst_i (rst_i),
        .raw   (nivel_alto_i),
        .filt  (alto)
    );

    bomba_antirrebote #(.DEB_CYC(DEB_CYC)) u_cist (
        .ck    (ck),
        .rst_i (rst_i),
        .raw   (cisterna_i),
        .filt  (cist)
    );

    estado_t       estado;
    estado_t       estado_n;
    logic [LW-1:0] lider;
    logic [LW-1:0] lider_n;
    logic [LW-1:0] lider_sig;
    logic [1:0]    causa;
    logic [1:0]    causa_n;
    logic [TW-1:0] fill_cnt;
    logic [TW-1:0] fill_n;
    logic [RW-1:0] rest_cnt;
    logic [RW-1:0] rest_n;
    logic          sensor;
    logic          libre;

    always_ff @(posedge ck or negedge rst_i) begin
        if (!rst_i) begin
            estado   <= ESPERA;
            lider    <= '0;
            causa    <= CAUSA_NINGUNA;
            fill_cnt <= '0;
            rest_cnt <= '0;
        end else begin
            estado   <= estado_n;
            lider    <= lider_n;
            causa    <= causa_n;
            fill_cnt <= fill_n;
            rest_cnt <= rest_n;
        end
    end

    assign sensor    = falla_sensor(alto, bajo);
    assign lider_sig = (lider == LW'(N_BOMBAS - 1)) ?
                       '0 : lider + 1'b1;

    always_comb begin
        libre = 1'b1;
        unique case (causa)
            CAUSA_SENSOR: libre = ~sensor;
            CAUSA_SECO:   libre = cist;
            default:      libre = 1'b1;
        endcase
    end

    // Counters idle at zero outside their own state, so entry clears them.
    always_comb begin
        estado_n = estado;
        lider_n  = lider;
        causa_n  = causa;
        fill_n   = '0;
        rest_n   = '0;
        unique case (estado)
            ESPERA: begin
                if (sensor) begin
                    estado_n = ALARMA;
                    causa_n  = CAUSA_SENSOR;
                end else if (!bajo) begin
                    if (!cist) begin
                        estado_n = ALARMA;
                        causa_n  = CAUSA_SECO;
                    end else begin
                        estado_n = LLENADO;
                    end
                end
            end
            LLENADO: begin
                if (sensor) begin
                    estado_n = ALARMA;
                    causa_n  = CAUSA_SENSOR;
                end else if (!cist) begin
                    estado_n = ALARMA;
                    causa_n  = CAUSA_SECO;
                end else if (alto) begin
                    estado_n = PAUSA;
                    lider_n  = lider_sig;
                end else if (fill_cnt ==
                             TW'(FILL_TIMEOUT_CYC - 1)) begin
                    estado_n = ALARMA;
                    causa_n  = CAUSA_TIMEOUT;
                    lider_n  = lider_sig;
                end else begin
                    fill_n = fill_cnt + 1'b1;
                end
            end
            PAUSA: begin
                if (sensor) begin
                    estado_n = ALARMA;
                    causa_n  = CAUSA_SENSOR;
                end else if (rest_cnt == RW'(MIN_OFF_CYC - 1)) begin
                    estado_n = ESPERA;
                end else begin
                    rest_n = rest_cnt + 1'b1;
                end
            end
            ALARMA: begin
                if (sensor && causa != CAUSA_SENSOR) begin
                    causa_n = CAUSA_SENSOR;
                end else if (!cist && !bajo &&
                             causa == CAUSA_TIMEOUT) begin
                    causa_n = CAUSA_SECO;
                end else if (ack_i && libre) begin
                    estado_n = ESPERA;
                    causa_n  = CAUSA_NINGUNA;
                end
            end
        endcase
    end

    always_comb begin
        bomba_o = '0;
        for (int i = 0; i < N_BOMBAS; i++) begin
            bomba_o[i] = (estado == LLENADO) &&
                         (lider == LW'(i));
        end
    end

    assign lider_o  = lider;
    assign alarma_o = (estado == ALARMA);
    assign causa_o  = causa;

endmodule

// File: tb/tb_bomba_multi.sv
// tb_bomba_multi: directed and randomized checks of bomba_multi
// against a window-based behavioural model of the controller.
module tb_bomba_multi;

    localparam int N   = 3;
    localparam int DEB = 4;
    localparam int MO  = 8;
    localparam int FT  = 64;
    localparam int LW  = 2;

    localparam int M_WAIT = 0;
    localparam int M_FILL = 1;
    localparam int M_REST = 2;
    localparam int M_ALM  = 3;

    logic          ck    = 1'b0;
    logic          rst_i = 1'b0;
    logic          nb    = 1'b1;
    logic          na    = 1'b1;
    logic          ci    = 1'b1;
    logic          ack   = 1'b0;
    logic [N-1:0]  bomba;
    logic [LW-1:0] lider;
    logic          alarma;
    logic [1:0]    causa;

    int total = 0;
    int bad   = 0;
    bit model_on = 1'b0;

    always #5 ck = ~ck;

    bomba_multi #(
        .N_BOMBAS         (N),
        .DEB_CYC          (DEB),
        .MIN_OFF_CYC      (MO),
        .FILL_TIMEOUT_CYC (FT)
    ) dut (
        .ck           (ck),
        .rst_i        (rst_i),
        .nivel_bajo_i (nb),
        .nivel_alto_i (na),
        .cisterna_i   (ci),
        .ack_i        (ack),
        .bomba_o      (bomba),
        .lider_o      (lider),
        .alarma_o     (alarma),
        .causa_o      (causa)
    );

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    // Model state: abstract mode, lead pump, cause, time spent in mode.
    int mode, lead, cause, fill_len, rest_len;
    bit f_b, f_a, f_c;
    bit qb[0:DEB];
    bit qa[0:DEB];
    bit qc[0:DEB];

    // Filter flips once the last DEB synced samples all disagree.
    function automatic bit deb(input bit f, input bit q[0:DEB]);
        for (int i = 1; i <= DEB; i++)
            if (q[i] == f) return f;
        return !f;
    endfunction

    always @(posedge ck or negedge rst_i) begin
        int now;
        bit sens;
        if (!rst_i) begin
            mode = M_WAIT; lead = 0; cause = 0;
            fill_len = 0; rest_len = 0;
            f_b = 1; f_a = 1; f_c = 1;
            for (int i = 0; i <= DEB; i++) begin
                qb[i] = 1; qa[i] = 1; qc[i] = 1;
            end
        end else begin
            sens = f_a && !f_b;
            now  = sens ? 1 : ((!f_c && !f_b) ? 2 : 0);
            case (mode)
                M_WAIT: begin
                    if (now != 0) begin
                        mode = M_ALM; cause = now;
                    end else if (!f_b) begin
                        mode = M_FILL; fill_len = 1;
                    end
                end
                M_FILL: begin
                    if (sens) begin
                        mode = M_ALM; cause = 1;
                    end else if (!f_c) begin
                        mode = M_ALM; cause = 2;
                    end else if (f_a) begin
                        mode = M_REST; rest_len = 1;
                        lead = (lead + 1) % N;
                    end else if (fill_len == FT) begin
                        mode = M_ALM; cause = 3;
                        lead = (lead + 1) % N;
                    end else begin
                        fill_len++;
                    end
                end
                M_REST: begin
                    if (sens) begin
                        mode = M_ALM; cause = 1;
                    end else if (rest_len == MO) begin
                        mode = M_WAIT;
                    end else begin
                        rest_len++;
                    end
                end
                default: begin
                    if (now != 0 && now < cause) begin
                        cause = now;
                    end else if (ack && (cause == 3 ||
                               (cause == 2 && f_c) ||
                               (cause == 1 && !sens))) begin
                        mode = M_WAIT; cause = 0;
                    end
                end
            endcase
            f_b = deb(f_b, qb);
            f_a = deb(f_a, qa);
            f_c = deb(f_c, qc);
            for (int i = DEB; i > 0; i--) begin
                qb[i] = qb[i-1]; qa[i] = qa[i-1]; qc[i] = qc[i-1];
            end
            qb[0] = nb; qa[0] = na; qc[0] = ci;
        end
    end

    always @(negedge ck) begin
        if (rst_i && model_on) begin
            chk("m_bomba", 32'(bomba),
                (mode == M_FILL) ? (32'd1 << lead) : 32'd0);
            chk("m_lider", 32'(lider), 32'(lead));
            chk("m_alarma", 32'(alarma), 32'(mode == M_ALM));
            chk("m_causa", 32'(causa),
                (mode == M_ALM) ? 32'(cause) : 32'd0);
        end
    end

    task automatic zero_chk(input string tag);
        chk({tag, "_bomba"}, 32'(bomba), 32'd0);
        chk({tag, "_lider"}, 32'(lider), 32'd0);
        chk({tag, "_alarma"}, 32'(alarma), 32'd0);
        chk({tag, "_causa"}, 32'(causa), 32'd0);
    endtask

    initial begin
        int lvl;
        repeat (3) @(negedge ck);
        zero_chk("reset");
        rst_i = 1; model_on = 1;
        repeat (2) @(negedge ck);

        nb = 0; na = 0;
        repeat (6) @(negedge ck);
        chk("pre_pump", 32'(bomba), 32'd0);
        @(negedge ck);
        chk("first_pump", 32'(bomba), 32'b001);
        nb = 1; na = 1;
        repeat (6) @(negedge ck);
        chk("still_pump", 32'(bomba), 32'b001);
        @(negedge ck);
        chk("fill_done", 32'(bomba), 32'd0);
        chk("lead_adv", 32'(lider), 32'd1);

        nb = 0;
        repeat (7) @(negedge ck);
        chk("sens_alarm", 32'(alarma), 32'd1);
        chk("sens_causa", 32'(causa), 32'b01);
        ack = 1;
        repeat (3) @(negedge ck);
        chk("sens_hold", 32'(alarma), 32'd1);
        #2 rst_i = 0;
        #1 zero_chk("async_rst");
        @(negedge ck);
        nb = 1; na = 1; ack = 0;
        @(negedge ck);
        rst_i = 1;
        @(negedge ck);

        nb = 0; na = 0;
        repeat (7) @(negedge ck);
        chk("fill2", 32'(bomba), 32'b001);
        ci = 0;
        repeat (7) @(negedge ck);
        chk("dry_bomba", 32'(bomba), 32'd0);
        chk("dry_causa", 32'(causa), 32'b10);
        ack = 1;
        repeat (4) @(negedge ck);
        chk("dry_hold", 32'(alarma), 32'd1);
        ci = 1;
        repeat (7) @(negedge ck);
        chk("dry_exit", 32'(alarma), 32'd0);
        @(negedge ck);
        chk("refill", 32'(bomba), 32'b001);
        repeat (63) @(negedge ck);
        chk("tmo_last", 32'(bomba), 32'b001);
        @(negedge ck);
        chk("tmo_causa", 32'(causa), 32'b11);
        chk("tmo_lead", 32'(lider), 32'd1);
        @(negedge ck);
        chk("tmo_exit", 32'(alarma), 32'd0);
        @(negedge ck);
        chk("next_pump", 32'(bomba), 32'b010);
        ack = 0;

        lvl = 0;
        for (int c = 0; c < 6000; c++) begin
            int r;
            @(negedge ck);
            if (c == 3000) begin
                #2 rst_i = 0;
                #1 zero_chk("rand_rst");
                @(negedge ck);
                rst_i = 1;
            end
            r = $urandom_range(0, 999);
            if (r < 25) lvl = (lvl > 0) ? lvl - 1 : lvl;
            else if (r < 50) lvl = (lvl < 2) ? lvl + 1 : lvl;
            else if (r < 53) lvl = 3;
            case (lvl)
                0:       begin nb = 0; na = 0; end
                1:       begin nb = 1; na = 0; end
                2:       begin nb = 1; na = 1; end
                default: begin nb = 0; na = 1; end
            endcase
            if ($urandom_range(0, 199) == 0) ci = ~ci;
            ack = ($urandom_range(0, 7) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
